// File: rtl/acc_sequencer_pkg.sv
// Shared definitions for the accumulator batch sequencer: FSM state encoding
// and the sticky-error source selection helper.
package acc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic err_flag(input logic signed_mode, input logic ovf, input logic carry);
    err_flag = signed_mode ? ovf : carry;
  endfunction

endpackage

// File: rtl/acc_sequencer_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module acc_sequencer_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointers; a write is refused while full even if a pop coincides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// Batch controller for the add/sub accumulator: buffers commands, clears the
// accumulator, issues one op per command and returns the batch sum and flags.
module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 4,
  parameter int SIGNED      = 1,
  parameter int STOP_ON_OVF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sub,
  input  logic             cmd_last,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_sub,
  output logic             acc_en,
  output logic             acc_clr,
  input  logic [WIDTH-1:0] acc_sum,
  input  logic             acc_overflow,
  input  logic             acc_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);
  localparam int               EW          = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             SIGNED_MODE = (SIGNED != 0);
  localparam logic             STOP_MODE   = (STOP_ON_OVF != 0);

  state_t           state_r, next_state_s;
  logic [EW-1:0]    head_s, wdata_s;
  logic [WIDTH:0]   next_head_s;
  logic             full_s, empty_s, push_s, pop_s, issue_next_s;
  logic             head_last_s, err_next_s;
  logic             acc_en_r, acc_clr_r, acc_sub_r, busy_r, res_valid_r;
  logic             last_r, err_r;
  logic [WIDTH-1:0] acc_in_r, res_data_r;
  logic [CNT_W-1:0] count_r;

  assign wdata_s     = {cmd_last, cmd_sub, cmd_data};
  assign push_s      = cmd_valid && !full_s;
  assign head_last_s = head_s[EW-1];
  assign err_next_s  = err_r | err_flag(SIGNED_MODE, acc_overflow, acc_carry);

  assign cmd_ready = !full_s;
  assign acc_in    = acc_in_r;
  assign acc_sub   = acc_sub_r;
  assign acc_en    = acc_en_r;
  assign acc_clr   = acc_clr_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_err   = err_r;
  assign res_count = count_r;
  assign busy      = busy_r;

  acc_sequencer_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; acc_en_r is high in ISSUE exactly when a head entry is being issued
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   if (!empty_s) next_state_s = ST_CLEAR; else next_state_s = ST_IDLE;
      ST_CLEAR:  next_state_s = ST_ISSUE;
      ST_ISSUE:  if (acc_en_r) next_state_s = ST_SAMPLE; else next_state_s = ST_ISSUE;
      ST_SAMPLE: begin
        if (last_r)                      next_state_s = ST_DONE;
        else if (STOP_MODE && err_next_s) next_state_s = ST_DRAIN;
        else                             next_state_s = ST_ISSUE;
      end
      ST_DRAIN:  if (!empty_s && head_last_s) next_state_s = ST_DONE; else next_state_s = ST_DRAIN;
      ST_DONE:   if (res_ready) next_state_s = ST_IDLE; else next_state_s = ST_DONE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Pop control and look-ahead of the entry to present when ISSUE is entered
  always_comb begin
    pop_s        = 1'b0;
    issue_next_s = 1'b0;
    next_head_s  = head_s[WIDTH:0];
    case (state_r)
      ST_ISSUE: pop_s = acc_en_r;
      ST_DRAIN: pop_s = !empty_s;
      default:  pop_s = 1'b0;
    endcase
    if (next_state_s == ST_ISSUE) begin
      if (empty_s) begin
        issue_next_s = push_s;
        next_head_s  = wdata_s[WIDTH:0];
      end else begin
        issue_next_s = 1'b1;
        next_head_s  = head_s[WIDTH:0];
      end
    end else begin
      issue_next_s = 1'b0;
      next_head_s  = head_s[WIDTH:0];
    end
  end

  // Registered strobes and accumulator operand; operand holds while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_en_r    <= 1'b0;
      acc_clr_r   <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      acc_in_r    <= {WIDTH{1'b0}};
      acc_sub_r   <= 1'b0;
    end else begin
      acc_en_r    <= issue_next_s;
      acc_clr_r   <= (next_state_s == ST_CLEAR);
      busy_r      <= (next_state_s != ST_IDLE);
      res_valid_r <= (next_state_s == ST_DONE);
      if (issue_next_s) begin
        acc_in_r  <= next_head_s[WIDTH-1:0];
        acc_sub_r <= next_head_s[WIDTH];
      end else begin
        acc_in_r  <= acc_in_r;
        acc_sub_r <= acc_sub_r;
      end
    end
  end

  // Per-batch bookkeeping: sticky error, saturating op count, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r      <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      last_r     <= 1'b0;
      res_data_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          err_r   <= 1'b0;
          count_r <= {CNT_W{1'b0}};
        end
        ST_ISSUE: begin
          if (acc_en_r) begin
            last_r <= head_last_s;
            if (count_r != CNT_MAX) count_r <= count_r + CNT_ONE;
            else                    count_r <= count_r;
          end else begin
            last_r <= last_r;
          end
        end
        ST_SAMPLE: begin
          err_r <= err_next_s;
          if (last_r) res_data_r <= acc_sum;
          else        res_data_r <= res_data_r;
        end
        ST_DRAIN: begin
          if (!empty_s && head_last_s) res_data_r <= acc_sum;
          else                         res_data_r <= res_data_r;
        end
        default: begin
          err_r <= err_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomised scoreboard bench for acc_sequencer paired with a behavioural
// add/sub accumulator; directed scenarios cover the listed corner cases.
module tb_acc_sequencer;
  localparam int WIDTH = 8, DEPTH = 4, CNT_W = 4, SIGNED = 1, STOP_ON_OVF = 1;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_sub, cmd_last;
  logic [7:0] cmd_data;
  logic [7:0] acc_in, acc_sum;
  logic acc_sub, acc_en, acc_clr, acc_overflow, acc_carry;
  logic res_valid, res_ready, res_err, busy;
  logic [7:0] res_data;
  logic [3:0] res_count;

  always #5 clk = ~clk;

  acc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .SIGNED(SIGNED),
                  .STOP_ON_OVF(STOP_ON_OVF)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_sub(cmd_sub), .cmd_last(cmd_last),
    .acc_in(acc_in), .acc_sub(acc_sub), .acc_en(acc_en), .acc_clr(acc_clr),
    .acc_sum(acc_sum), .acc_overflow(acc_overflow), .acc_carry(acc_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_count(res_count), .busy(busy)
  );

  // Add/sub accumulator peer; acc_clr acts as its reset
  logic [8:0] add9, sub9;
  logic [7:0] nsum;
  logic ncy, nov;
  always_comb begin
    add9 = {1'b0, acc_sum} + {1'b0, acc_in};
    sub9 = {1'b0, acc_sum} - {1'b0, acc_in};
    nsum = acc_sub ? sub9[7:0] : add9[7:0];
    ncy  = acc_sub ? sub9[8] : add9[8];
    nov  = acc_sub ? ((acc_sum[7] != acc_in[7]) && (nsum[7] != acc_sum[7]))
                   : ((acc_sum[7] == acc_in[7]) && (nsum[7] != acc_sum[7]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || acc_clr) begin
      acc_sum <= 8'd0; acc_overflow <= 1'b0; acc_carry <= 1'b0;
    end else if (acc_en) begin
      acc_sum <= nsum; acc_overflow <= nov; acc_carry <= ncy;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference model: batch arithmetic on plain integers
  typedef struct { int data; int err; int count; int issued; } exp_t;
  typedef struct { int d; int s; } op_t;
  exp_t exp_q[$];
  op_t  iss_q[$];
  int m_sum = 0, m_err = 0, m_cnt = 0, m_stop = 0;

  task automatic model_reset();
    m_sum = 0; m_err = 0; m_cnt = 0; m_stop = 0;
  endtask

  task automatic model_accept(input int d, input int s, input int l);
    int sv, dv, r, cy, ov;
    exp_t e;
    op_t o;
    if (m_stop == 0) begin
      o.d = d; o.s = s; iss_q.push_back(o);
      sv = (m_sum >= 128) ? m_sum - 256 : m_sum;
      dv = (d >= 128) ? d - 256 : d;
      r  = (s != 0) ? sv - dv : sv + dv;
      ov = (r > 127 || r < -128) ? 1 : 0;
      cy = (s != 0) ? ((m_sum < d) ? 1 : 0) : ((m_sum + d > 255) ? 1 : 0);
      if (((SIGNED != 0) ? ov : cy) != 0) m_err = 1;
      m_cnt++;
      m_sum = ((r % 256) + 256) % 256;
      if (STOP_ON_OVF != 0 && m_err != 0 && l == 0) m_stop = 1;
    end
    if (l != 0) begin
      e.data = m_sum; e.err = m_err; e.count = (m_cnt > CNT_SAT) ? CNT_SAT : m_cnt;
      e.issued = m_cnt;
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  // Monitor: operand checks on acc_en, result checks on handshake, hold checks on stall
  int n_en = 0, n_clr = 0, n_res = 0;
  int last_data = -1, last_err = -1, last_count = -1;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_err;
  logic [3:0] prev_count;
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_clr) n_clr++;
      if (acc_en) begin
        n_en++;
        if (iss_q.size() == 0) begin
          check("unexpected_acc_en", 1, 0);
        end else begin
          op_t o;
          o = iss_q.pop_front();
          check("acc_in", int'(acc_in), o.d);
          check("acc_sub", int'(acc_sub), o.s);
        end
      end
      if (res_valid && prev_stall) begin
        check("hold_data", int'(res_data), int'(prev_data));
        check("hold_err", int'(res_err), int'(prev_err));
        check("hold_count", int'(res_count), int'(prev_count));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", int'(res_data), e.data);
          check("res_err", int'(res_err), e.err);
          check("res_count", int'(res_count), e.count);
          check("acc_en_pulses", n_en, e.issued);
          check("acc_clr_pulses", n_clr, 1);
        end
        last_data = int'(res_data); last_err = int'(res_err); last_count = int'(res_count);
        n_res++; n_en = 0; n_clr = 0;
      end
      prev_stall = res_valid && !res_ready;
      prev_data = res_data; prev_err = res_err; prev_count = res_count;
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic rr_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int d, input int s, input int l);
    int t = 0;
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_data = d[7:0]; cmd_sub = s[0]; cmd_last = l[0];
    while (!ok && t < 300) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; t++;
    end
    cmd_valid = 1'b0;
    if (ok) model_accept(d, s, l);
    else fail_now("push");
  endtask

  task automatic wait_res(input int target, input string name);
    int t = 0;
    while (n_res < target && t < 600) begin @(posedge clk); #1; t++; end
    if (n_res < target) fail_now(name);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_acc_en"}, int'(acc_en), 0);
    check({tag, "_acc_clr"}, int'(acc_clr), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_acc_in"}, int'(acc_in), 0);
    check({tag, "_acc_sub"}, int'(acc_sub), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
    check({tag, "_res_err"}, int'(res_err), 0);
    check({tag, "_res_count"}, int'(res_count), 0);
  endtask

  initial begin
    int t, strobes;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'd0; cmd_sub = 1'b0; cmd_last = 1'b0;
    res_ready = 1'b0;
    #1 check_quiet("reset");
    step(2); rst = 1'b0; res_ready = 1'b1;

    // basic batch: +5 +3 -2
    push(5, 0, 0); push(3, 0, 0); push(2, 1, 1);
    wait_res(1, "t1_result");
    check("t1_data", last_data, 6); check("t1_err", last_err, 0); check("t1_count", last_count, 3);

    // signed overflow on the last op
    push(100, 0, 0); push(100, 0, 1);
    wait_res(2, "t2_result");
    check("t2_data", last_data, 200); check("t2_err", last_err, 1); check("t2_count", last_count, 2);

    // stop on overflow: +5 is discarded
    push(127, 0, 0); push(1, 0, 0); push(5, 0, 1);
    wait_res(3, "t3_result");
    check("t3_data", last_data, 128); check("t3_err", last_err, 1); check("t3_count", last_count, 2);

    // starvation gap inside a batch
    push(1, 0, 0); step(4);
    repeat (4) begin
      @(negedge clk); check("gap_acc_en", int'(acc_en), 0); check("gap_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    push(1, 0, 1);
    wait_res(4, "t5_result");
    check("t5_data", last_data, 2); check("t5_count", last_count, 2);

    // result stalled in DONE while the FIFO fills
    res_ready = 1'b0;
    push(4, 0, 1);
    t = 0;
    while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (!res_valid) fail_now("t4_valid");
    push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(4, 0, 1);
    cmd_valid = 1'b1; cmd_data = 8'd9; cmd_sub = 1'b0; cmd_last = 1'b1;
    @(negedge clk);
    check("t4_full_ready", int'(cmd_ready), 0);
    check("t4_held_valid", int'(res_valid), 1);
    check("t4_held_data", int'(res_data), 4);
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b1;
    push(9, 0, 1);
    wait_res(7, "t4_result");
    check("t4_last_data", last_data, 9);

    // reset in the middle of a batch
    push(10, 0, 0); push(20, 0, 0); push(30, 0, 1);
    t = 0;
    while (t < 50) begin @(negedge clk); if (acc_en) break; t++; end
    if (t >= 50) fail_now("t6_first_en");
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_quiet("midreset");
    exp_q.delete(); iss_q.delete(); model_reset(); n_en = 0; n_clr = 0;
    @(posedge clk); #1; rst = 1'b0;
    strobes = 0;
    repeat (6) begin @(negedge clk); if (acc_en || acc_clr || busy) strobes++; end
    check("t6_no_strobes", strobes, 0);
    @(posedge clk); #1;
    push(7, 0, 1);
    wait_res(n_res + 1, "t6_result");
    check("t6_data", last_data, 7);

    // count saturation: 17 increments
    for (int i = 0; i < 17; i++) push(1, 0, (i == 16) ? 1 : 0);
    wait_res(n_res + 1, "sat_result");
    check("sat_data", last_data, 17); check("sat_count", last_count, CNT_SAT);

    // randomised batches with random back-pressure
    rr_rand = 1'b1;
    for (int b = 0; b < 30; b++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        step($urandom_range(0, 2));
        push($urandom_range(0, 255), $urandom_range(0, 1), (i == len - 1) ? 1 : 0);
      end
    end
    rr_rand = 1'b0; res_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) fail_now("drain_results");
    check("leftover_ops", iss_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
